// File: rtl/cpu_pkg.sv
// Shared definitions for the 19-bit CPU: sequencer states, opcode map and
// default widths.
package cpu_pkg;

  localparam int DEF_PC_W   = 19;
  localparam int DEF_DATA_W = 19;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } seq_state_t;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_SUB  = 5'h02;
  localparam logic [4:0] OP_AND  = 5'h03;
  localparam logic [4:0] OP_OR   = 5'h04;
  localparam logic [4:0] OP_XOR  = 5'h05;
  localparam logic [4:0] OP_SHL  = 5'h06;
  localparam logic [4:0] OP_SHR  = 5'h07;
  localparam logic [4:0] OP_LD   = 5'h08;
  localparam logic [4:0] OP_ST   = 5'h09;
  localparam logic [4:0] OP_BEQ  = 5'h0A;
  localparam logic [4:0] OP_BNE  = 5'h0B;
  localparam logic [4:0] OP_JMP  = 5'h0C;
  localparam logic [4:0] OP_CALL = 5'h0D;
  localparam logic [4:0] OP_RET  = 5'h0E;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer bus: decoder strobes, branch info, memory handshakes and the
// timed enables the sequencer hands back. master = sequencer side.
interface cpu_sequencer_if import cpu_pkg::*; #(
  parameter int PC_W = DEF_PC_W
);
  logic            regwr, memrd, memwr, branch, jump, call, ret;
  logic            br_taken;
  logic [PC_W-1:0] target;
  logic            imem_ready, dmem_ready;
  logic [PC_W-1:0] pc;
  logic            imem_req, ir_ld, dmem_req, dmem_we, rf_we, trap;

  modport master (
    input  regwr, memrd, memwr, branch, jump, call, ret,
    input  br_taken, target, imem_ready, dmem_ready,
    output pc, imem_req, ir_ld, dmem_req, dmem_we, rf_we, trap
  );

  modport slave (
    output regwr, memrd, memwr, branch, jump, call, ret,
    output br_taken, target, imem_ready, dmem_ready,
    input  pc, imem_req, ir_ld, dmem_req, dmem_we, rf_we, trap
  );
endinterface

// File: rtl/cpu_sequencer_call_stack.sv
// Return-address LIFO. With CALL_STACK_CHECK_EN an occupancy count drives
// full/empty; otherwise the pointer simply wraps and the flags read 0.
module call_stack import cpu_pkg::*; #(
  parameter int PC_W        = DEF_PC_W,
  parameter int STACK_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] dout,
  output logic            full,
  output logic            empty
);
  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [PC_W-1:0]  mem [STACK_DEPTH];
  logic [PTR_W-1:0] sp;
  logic [PTR_W-1:0] sp_dec;

  // sp points at the next free slot, so the top of stack sits one below it.
  assign sp_dec = sp - PTR_W'(1);
  assign dout   = mem[sp_dec];

  always_ff @(posedge clk) begin
    if (push) mem[sp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst)       sp <= '0;
    else if (push) sp <= sp + PTR_W'(1);
    else if (pop)  sp <= sp_dec;
  end

`ifdef CALL_STACK_CHECK_EN
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (push) cnt <= cnt + CNT_W'(1);
    else if (pop)  cnt <= cnt - CNT_W'(1);
  end

  assign full  = (cnt == CNT_W'(STACK_DEPTH));
  assign empty = (cnt == '0);
`else
  assign full  = 1'b0;
  assign empty = 1'b0;
`endif

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with PC and call stack.
// Optional stack over/underflow trapping: define CALL_STACK_CHECK_EN.
module cpu_sequencer import cpu_pkg::*; #(
  parameter int              PC_W        = DEF_PC_W,
  parameter int              STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input logic             clk,
  input logic             rst,
  cpu_sequencer_if.master bus
);
  seq_state_t      state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic            push, pop;
  logic [PC_W-1:0] stk_top;
  logic            stk_full, stk_empty;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] a);
    return a + PC_W'(1);
  endfunction

  call_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc(pc)),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    state_n = state;
    pc_n    = pc;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state)
      ST_FETCH:  if (bus.imem_ready) state_n = ST_DECODE;
      ST_DECODE: state_n = ST_EXEC;
      ST_EXEC: begin
        if (bus.ret) begin
          if (stk_empty) state_n = ST_TRAP;
          else begin
            pop     = 1'b1;
            pc_n    = stk_top;
            state_n = ST_FETCH;
          end
        end else if (bus.call) begin
          if (stk_full) state_n = ST_TRAP;
          else begin
            push    = 1'b1;
            pc_n    = bus.target;
            state_n = ST_FETCH;
          end
        end else if (bus.jump) begin
          pc_n    = bus.target;
          state_n = ST_FETCH;
        end else if (bus.branch) begin
          pc_n    = bus.br_taken ? bus.target : pc_inc(pc);
          state_n = ST_FETCH;
        end else if (bus.memrd || bus.memwr) begin
          state_n = ST_MEM;
        end else if (bus.regwr) begin
          state_n = ST_WB;
        end else begin
          pc_n    = pc_inc(pc);
          state_n = ST_FETCH;
        end
      end
      ST_MEM: begin
        // In MEM a clear dmem_we means the access is a load.
        if (bus.dmem_ready) begin
          if (!bus.dmem_we) state_n = ST_WB;
          else begin
            pc_n    = pc_inc(pc);
            state_n = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        pc_n    = pc_inc(pc);
        state_n = ST_FETCH;
      end
      ST_TRAP: state_n = ST_TRAP;
      default: state_n = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_FETCH;
      pc           <= RESET_PC;
      bus.imem_req <= 1'b1;
      bus.dmem_req <= 1'b0;
      bus.dmem_we  <= 1'b0;
      bus.rf_we    <= 1'b0;
`ifdef CALL_STACK_CHECK_EN
      bus.trap     <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      bus.imem_req <= (state_n == ST_FETCH);
      bus.dmem_req <= (state_n == ST_MEM);
      bus.rf_we    <= (state_n == ST_WB);
      // Write qualifier is captured from the decoder in EXEC; memrd wins.
      bus.dmem_we  <= (state_n == ST_MEM) &&
                      ((state == ST_EXEC) ? (bus.memwr && !bus.memrd) : bus.dmem_we);
`ifdef CALL_STACK_CHECK_EN
      if (state_n == ST_TRAP) bus.trap <= 1'b1;
`endif
    end
  end

`ifndef CALL_STACK_CHECK_EN
  assign bus.trap = 1'b0;
`endif

  assign bus.pc    = pc;
  assign bus.ir_ld = (state == ST_FETCH) && bus.imem_ready;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus random instruction streams
// checked cycle by cycle against an instruction-level reference model.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int              PC_W   = 19;
  localparam int              DEPTH  = 8;
  localparam logic [PC_W-1:0] RST_PC = '0;

  localparam logic [6:0] S_RET    = 7'h01;
  localparam logic [6:0] S_CALL   = 7'h02;
  localparam logic [6:0] S_JUMP   = 7'h04;
  localparam logic [6:0] S_BRANCH = 7'h08;
  localparam logic [6:0] S_MEMWR  = 7'h10;
  localparam logic [6:0] S_MEMRD  = 7'h20;
  localparam logic [6:0] S_REGWR  = 7'h40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.PC_W(PC_W)) bus ();

  cpu_sequencer #(
    .PC_W        (PC_W),
    .STACK_DEPTH (DEPTH),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [PC_W-1:0] mpc;
  bit              mtrap;
`ifdef CALL_STACK_CHECK_EN
  logic [PC_W-1:0] stk[$];
`else
  logic [PC_W-1:0] ring [DEPTH];
  int              rptr;
`endif

  task automatic check_out(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [PC_W-1:0] p, input bit ireq, input bit irl,
                                     input bit dreq, input bit dwe, input bit rfwe, input bit tr);
    return {7'b0, p, ireq, irl, dreq, dwe, rfwe, tr};
  endfunction

  function automatic logic [31:0] obs();
    return {7'b0, bus.pc, bus.imem_req, bus.ir_ld, bus.dmem_req, bus.dmem_we, bus.rf_we, bus.trap};
  endfunction

  function automatic logic [PC_W-1:0] nxt(input logic [PC_W-1:0] p);
    return PC_W'((int'(p) + 1) % (1 << PC_W));
  endfunction

  // Reference return-address stack.
  function automatic bit m_full();
`ifdef CALL_STACK_CHECK_EN
    return stk.size() == DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_empty();
`ifdef CALL_STACK_CHECK_EN
    return stk.size() == 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_push(input logic [PC_W-1:0] v);
`ifdef CALL_STACK_CHECK_EN
    stk.push_back(v);
`else
    ring[rptr] = v;
    rptr = (rptr + 1) % DEPTH;
`endif
  endtask

  task automatic m_pop(output logic [PC_W-1:0] v);
`ifdef CALL_STACK_CHECK_EN
    v = stk.pop_back();
`else
    rptr = (rptr + DEPTH - 1) % DEPTH;
    v = ring[rptr];
`endif
  endtask

  task automatic m_reset();
    mpc   = RST_PC;
    mtrap = 1'b0;
`ifdef CALL_STACK_CHECK_EN
    stk.delete();
`else
    rptr = 0;
`endif
  endtask

  task automatic drive(input bit r, input logic [6:0] s, input bit br, input logic [PC_W-1:0] tgt,
                       input bit ir, input bit dr);
    @(negedge clk);
    rst = r;
    {bus.regwr, bus.memrd, bus.memwr, bus.branch, bus.jump, bus.call, bus.ret} = s;
    bus.br_taken   = br;
    bus.target     = tgt;
    bus.imem_ready = ir;
    bus.dmem_ready = dr;
    #1;
  endtask

  task automatic cyc(input string tag, input logic [6:0] s, input bit br, input logic [PC_W-1:0] tgt,
                     input bit ir, input bit dr, input logic [31:0] exp);
    drive(1'b0, s, br, tgt, ir, dr);
    check_out(tag, obs(), exp);
  endtask

  task automatic do_reset();
    drive(1'b1, 7'h0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, 7'h0, 1'b0, '0, 1'b0, 1'b0);
    m_reset();
    check_out("reset", obs(), mk(RST_PC, 1, 0, 0, 0, 0, 0));
  endtask

  // One full instruction from FETCH until the sequencer is back in FETCH.
  task automatic run_instr(input logic [6:0] s, input bit br, input logic [PC_W-1:0] tgt,
                           input int iw, input int dw);
    logic [PC_W-1:0] v;
    bit              we;
    repeat (iw) cyc("fetch_wait", 7'h0, 0, '0, 0, 0, mk(mpc, 1, 0, 0, 0, 0, 0));
    cyc("fetch", 7'h0, 0, '0, 1, 0, mk(mpc, 1, 1, 0, 0, 0, 0));
    cyc("decode", s, br, tgt, 0, 0, mk(mpc, 0, 0, 0, 0, 0, 0));
    cyc("exec", s, br, tgt, 0, 0, mk(mpc, 0, 0, 0, 0, 0, 0));
    if (s[0]) begin
      if (m_empty()) mtrap = 1'b1;
      else begin
        m_pop(v);
        mpc = v;
      end
    end else if (s[1]) begin
      if (m_full()) mtrap = 1'b1;
      else begin
        m_push(nxt(mpc));
        mpc = tgt;
      end
    end else if (s[2]) begin
      mpc = tgt;
    end else if (s[3]) begin
      mpc = br ? tgt : nxt(mpc);
    end else if (s[5] || s[4]) begin
      we = !s[5];
      repeat (dw) cyc("mem_wait", 7'h0, 0, '0, 0, 0, mk(mpc, 0, 0, 1, we, 0, 0));
      cyc("mem", 7'h0, 0, '0, 0, 1, mk(mpc, 0, 0, 1, we, 0, 0));
      if (!we) cyc("wb_load", 7'h0, 0, '0, 0, 0, mk(mpc, 0, 0, 0, 0, 1, 0));
      mpc = nxt(mpc);
    end else if (s[6]) begin
      cyc("wb_alu", 7'h0, 0, '0, 0, 0, mk(mpc, 0, 0, 0, 0, 1, 0));
      mpc = nxt(mpc);
    end else begin
      mpc = nxt(mpc);
    end
    if (mtrap) begin
      repeat (3)
        cyc("trap", 7'($urandom), 1'($urandom), PC_W'($urandom), 1'($urandom), 1'($urandom),
            mk(mpc, 0, 0, 0, 0, 0, 1));
      do_reset();
    end
  endtask

  initial begin
    logic [6:0] s;
    {bus.regwr, bus.memrd, bus.memwr, bus.branch, bus.jump, bus.call, bus.ret} = '0;
    bus.br_taken   = 1'b0;
    bus.target     = '0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    do_reset();

    // ALU op at 0x10
    run_instr(S_JUMP, 0, 19'h00010, 0, 0);
    run_instr(S_REGWR, 0, '0, 0, 0);

    // branches and jump-over-branch priority
    run_instr(S_JUMP, 0, 19'h00020, 1, 0);
    run_instr(S_BRANCH, 1, 19'h00100, 0, 0);
    run_instr(S_JUMP, 0, 19'h00020, 0, 0);
    run_instr(S_BRANCH, 0, 19'h00100, 0, 0);
    run_instr(S_JUMP | S_BRANCH, 0, 19'h00300, 0, 0);

    // load with 3 wait cycles, store, and memrd+memwr together
    run_instr(S_MEMRD, 0, '0, 0, 3);
    run_instr(S_MEMWR, 0, '0, 0, 0);
    run_instr(S_MEMRD | S_MEMWR, 0, '0, 2, 1);
    run_instr(S_MEMWR | S_REGWR, 0, '0, 0, 1);

    // call / ret
    run_instr(S_JUMP, 0, 19'h00005, 0, 0);
    run_instr(S_CALL, 0, 19'h00200, 0, 0);
    run_instr(S_RET, 0, 19'h12345, 0, 0);

    // nested calls to full depth then unwind
    for (int i = 0; i < DEPTH; i++) run_instr(S_CALL, 0, PC_W'($urandom), $urandom_range(0, 1), 0);
    for (int i = 0; i < DEPTH; i++) run_instr(S_RET, 0, PC_W'($urandom), 0, 0);
    run_instr(S_REGWR, 0, '0, 0, 0);

    // one call past the stack depth
    do_reset();
    for (int i = 0; i <= DEPTH; i++) run_instr(S_CALL, 0, PC_W'(19'h01000 + i * 16), 0, 0);
`ifndef CALL_STACK_CHECK_EN
    for (int i = 0; i <= DEPTH; i++) run_instr(S_RET, 0, '0, 0, 0);
`endif

    // reset while a data access is pending
    run_instr(S_JUMP, 0, 19'h00040, 0, 0);
    cyc("fetch", 7'h0, 0, '0, 1, 0, mk(mpc, 1, 1, 0, 0, 0, 0));
    cyc("decode", S_MEMRD, 0, '0, 0, 0, mk(mpc, 0, 0, 0, 0, 0, 0));
    cyc("exec", S_MEMRD, 0, '0, 0, 0, mk(mpc, 0, 0, 0, 0, 0, 0));
    cyc("mem_hold", 7'h0, 0, '0, 0, 0, mk(mpc, 0, 0, 1, 0, 0, 0));
    drive(1'b1, 7'h0, 0, '0, 0, 0);
    check_out("mem_pre_rst", obs(), mk(mpc, 0, 0, 1, 0, 0, 0));
    drive(1'b0, 7'h0, 0, '0, 0, 1);
    m_reset();
    check_out("mem_rst", obs(), mk(RST_PC, 1, 0, 0, 0, 0, 0));

    // PC wrap on NOP
    run_instr(S_JUMP, 0, 19'h7FFFF, 0, 0);
    run_instr(7'h0, 0, '0, 0, 0);
    run_instr(7'h0, 0, '0, 0, 0);

    // random instruction stream
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 7; b++) s[b] = ($urandom_range(0, 3) == 0);
      run_instr(s, 1'($urandom), PC_W'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    cyc("final_fetch", 7'h0, 0, '0, 0, 0, mk(mpc, 1, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
